// File: rtl/car_odometer.sv
// Car odometer: lifetime and trip mileage kept natively in packed BCD,
// advanced by a motion prescaler that retains partial distance across stops.
module car_odometer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  move_forward,
    input  logic                  move_backward,
    input  logic                  trip_clear,
    output logic [4*DIGITS-1:0]   total_bcd,
    output logic [4*DIGITS-1:0]   trip_bcd,
    output logic                  unit_tick,
    output logic                  total_wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]       prescaler;
    logic                moving;
    logic [4*DIGITS:0]   total_inc;
    logic [4*DIGITS:0]   trip_inc;

    // Digit-wise decimal increment; MSB of the result is the carry out of the
    // top digit, which is only set when every digit was 9.
    function automatic logic [4*DIGITS:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        r = v;
        c = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    always_comb begin
        moving    = move_forward | move_backward;
        unit_tick = moving && !reset && (prescaler == PMAX);
        total_inc = bcd_inc(total_bcd);
        trip_inc  = bcd_inc(trip_bcd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            total_bcd  <= '0;
            trip_bcd   <= '0;
            total_wrap <= 1'b0;
        end else begin
            total_wrap <= 1'b0;
            if (moving) begin
                if (prescaler == PMAX) begin
                    prescaler <= '0;
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
            if (unit_tick) begin
                total_bcd  <= total_inc[4*DIGITS-1:0];
                total_wrap <= total_inc[4*DIGITS];
                trip_bcd   <= trip_inc[4*DIGITS-1:0];
            end
            // A clear coincident with a tick still zeroes the trip counter.
            if (trip_clear) begin
                trip_bcd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_car_odometer.sv
// Directed bench for car_odometer: a 4-digit and a 2-digit instance share stimulus,
// both with TICK_DIV=4.
module tb_car_odometer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        move_forward = 1'b0;
    logic        move_backward = 1'b0;
    logic        trip_clear = 1'b0;
    logic [15:0] total_bcd, trip_bcd;
    logic        unit_tick, total_wrap;
    logic [7:0]  total_bcd2, trip_bcd2;
    logic        unit_tick2, total_wrap2;

    int n_assert = 0;
    int n_fail   = 0;
    int n_wrap1  = 0;
    int n_wrap2  = 0;
    int n_ticks  = 0;
    logic bad_digit = 1'b0;

    car_odometer #(.DIGITS(4), .TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .move_forward(move_forward),
        .move_backward(move_backward), .trip_clear(trip_clear),
        .total_bcd(total_bcd), .trip_bcd(trip_bcd),
        .unit_tick(unit_tick), .total_wrap(total_wrap)
    );

    car_odometer #(.DIGITS(2), .TICK_DIV(4)) dut2 (
        .clk(clk), .reset(reset), .move_forward(move_forward),
        .move_backward(move_backward), .trip_clear(trip_clear),
        .total_bcd(total_bcd2), .trip_bcd(trip_bcd2),
        .unit_tick(unit_tick2), .total_wrap(total_wrap2)
    );

    always #5 clk = ~clk;

    // Watch every digit and wrap pulse between edges.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (total_bcd[4*d +: 4] > 4'd9 || trip_bcd[4*d +: 4] > 4'd9) bad_digit = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            if (total_bcd2[4*d +: 4] > 4'd9 || trip_bcd2[4*d +: 4] > 4'd9) bad_digit = 1'b1;
        end
        if (total_wrap)  n_wrap1++;
        if (total_wrap2) n_wrap2++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the combinational tick before the edge, then advance one cycle.
    task automatic tick_step(input string tag, input logic exp_tick);
        #1;
        check(tag, {31'd0, unit_tick}, {31'd0, exp_tick});
        if (unit_tick) n_ticks++;
        cyc();
    endtask

    initial begin
        // Reset state, with motion asserted to show reset dominates.
        reset = 1'b1;
        move_forward = 1'b1;
        cyc();
        #1;
        check("reset_tick", {31'd0, unit_tick}, 32'd0);
        cyc();
        check("reset_total", {16'd0, total_bcd}, 32'h0);
        check("reset_trip", {16'd0, trip_bcd}, 32'h0);
        check("reset_wrap", {31'd0, total_wrap}, 32'd0);

        // Twelve forward cycles: ticks on cycles 4, 8, 12.
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick_step($sformatf("fwd12_tick_c%0d", i), (i % 4) == 0);
        end
        check("fwd12_total", {16'd0, total_bcd}, 32'h0003);
        check("fwd12_trip", {16'd0, trip_bcd}, 32'h0003);
        check("fwd12_total_d2", {24'd0, total_bcd2}, 32'h03);

        // Move 2, stop 10, move 2: single tick on the 4th moving cycle.
        reset = 1'b1;
        move_forward = 1'b0;
        cyc();
        reset = 1'b0;
        n_ticks = 0;
        move_forward = 1'b1;
        tick_step("stop_m1", 1'b0);
        tick_step("stop_m2", 1'b0);
        move_forward = 1'b0;
        for (int i = 0; i < 10; i++) tick_step("stop_idle", 1'b0);
        move_forward = 1'b1;
        tick_step("stop_m3", 1'b0);
        tick_step("stop_m4", 1'b1);
        check("stop_tick_count", n_ticks, 32'd1);
        check("stop_total", {16'd0, total_bcd}, 32'h0001);
        check("stop_trip", {16'd0, trip_bcd}, 32'h0001);

        // 39 ticks, then decimal carry 39 -> 40.
        move_forward = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        move_forward = 1'b1;
        repeat (39 * 4) cyc();
        check("pre39_total", {16'd0, total_bcd}, 32'h0039);
        check("pre39_total_d2", {24'd0, total_bcd2}, 32'h39);
        repeat (4) cyc();
        check("carry40_total", {16'd0, total_bcd}, 32'h0040);
        check("carry40_trip", {16'd0, trip_bcd}, 32'h0040);

        // Continue to 99 ticks, then the 2-digit instance rolls over.
        repeat (59 * 4) cyc();
        check("pre99_total_d2", {24'd0, total_bcd2}, 32'h99);
        check("pre99_trip_d2", {24'd0, trip_bcd2}, 32'h99);
        check("pre99_wrap_d2", {31'd0, total_wrap2}, 32'd0);
        repeat (4) cyc();
        check("wrap_total_d2", {24'd0, total_bcd2}, 32'h00);
        check("wrap_trip_d2", {24'd0, trip_bcd2}, 32'h00);
        check("wrap_flag_d2", {31'd0, total_wrap2}, 32'd1);
        check("wrap_total_d4", {16'd0, total_bcd}, 32'h0100);
        check("wrap_flag_d4", {31'd0, total_wrap}, 32'd0);
        move_forward = 1'b0;
        cyc();
        check("wrap_flag_d2_after", {31'd0, total_wrap2}, 32'd0);
        check("wrap_total_d2_after", {24'd0, total_bcd2}, 32'h00);
        check("wrap_pulse_count_d2", n_wrap2, 32'd1);
        check("wrap_pulse_count_d4", n_wrap1, 32'd0);

        // Trip at 5, clear coincident with a tick: clear wins, total still advances.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        move_forward = 1'b1;
        repeat (5 * 4 + 3) cyc();
        check("pre_clr_trip", {16'd0, trip_bcd}, 32'h0005);
        trip_clear = 1'b1;
        tick_step("clr_tick", 1'b1);
        check("clr_tick_trip", {16'd0, trip_bcd}, 32'h0000);
        check("clr_tick_total", {16'd0, total_bcd}, 32'h0006);

        // Held clear while moving leaves prescaler and total alone.
        tick_step("hold_clr_m1", 1'b0);
        tick_step("hold_clr_m2", 1'b0);
        tick_step("hold_clr_m3", 1'b0);
        check("hold_clr_trip", {16'd0, trip_bcd}, 32'h0000);
        check("hold_clr_total", {16'd0, total_bcd}, 32'h0006);
        trip_clear = 1'b0;
        tick_step("hold_clr_m4", 1'b1);
        check("after_hold_total", {16'd0, total_bcd}, 32'h0007);
        check("after_hold_trip", {16'd0, trip_bcd}, 32'h0001);
        move_forward = 1'b0;
        trip_clear = 1'b1;
        cyc();
        trip_clear = 1'b0;
        check("idle_clr_trip", {16'd0, trip_bcd}, 32'h0000);
        check("idle_clr_total", {16'd0, total_bcd}, 32'h0007);

        // Both directions, reset at prescaler=2 discards progress.
        move_forward = 1'b1;
        move_backward = 1'b1;
        tick_step("both_m1", 1'b0);
        tick_step("both_m2", 1'b0);
        reset = 1'b1;
        tick_step("both_rst", 1'b0);
        check("both_rst_total", {16'd0, total_bcd}, 32'h0000);
        check("both_rst_trip", {16'd0, trip_bcd}, 32'h0000);
        check("both_rst_wrap", {31'd0, total_wrap}, 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick_step($sformatf("both_after_c%0d", i), i == 4);
        end
        check("both_after_total", {16'd0, total_bcd}, 32'h0001);

        check("digits_valid", {31'd0, bad_digit}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
